// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: register address type and register count.
// Imported by the decode-side scoreboard blocks.
package cpu_defs_pkg;

    localparam int REG_NUM = 32;

    typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/sb_busy_table.sv
// Per-GPR busy bits for outstanding long-latency writes.
// Readiness treats a register cleared this cycle as ready (RF write-through).
module sb_busy_table
    import cpu_defs_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set1,
    input  reg_addr_t             set_addr1,
    input  logic                  set2,
    input  reg_addr_t             set_addr2,
    input  logic                  clr1,
    input  reg_addr_t             clr_addr1,
    input  logic                  clr2,
    input  reg_addr_t             clr_addr2,
    input  reg_addr_t [5:0]       rd_addr,
    output logic      [5:0]       rdy
);

    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] set_vec;
    logic [REG_NUM-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set1) set_vec[set_addr1] = 1'b1;
        if (set2) set_vec[set_addr2] = 1'b1;
        if (clr1) clr_vec[clr_addr1] = 1'b1;
        if (clr2) clr_vec[clr_addr2] = 1'b1;
        // r0 is never tracked
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
    end

    // set wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
        end
    end

    always_comb begin
        rdy = '0;
        for (int i = 0; i < 6; i++) begin
            rdy[i] = ~busy[rd_addr[i]] | clr_vec[rd_addr[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!clr1 || busy[clr_addr1]);
            assert (!clr2 || busy[clr_addr2]);
            assert (!(clr1 && clr2 && clr_addr1 == clr_addr2));
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and dual-issue gate for the master/slave pipeline.
// Issue decisions are combinational from registered state plus this cycle.
module issue_scoreboard
    import cpu_defs_pkg::*;
#(
    parameter  int MAX_PENDING = 4,
    localparam int PW          = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          a_valid,
    input  logic          b_valid,
    input  reg_addr_t     a_rs,
    input  reg_addr_t     a_rt,
    input  reg_addr_t     b_rs,
    input  reg_addr_t     b_rt,
    input  logic          a_rs_use,
    input  logic          a_rt_use,
    input  logic          b_rs_use,
    input  logic          b_rt_use,
    input  logic          a_wen,
    input  logic          b_wen,
    input  reg_addr_t     a_dst,
    input  reg_addr_t     b_dst,
    input  logic          a_long,
    input  logic          b_long,
    input  logic          wen1,
    input  reg_addr_t     wa1,
    input  logic          wb1_long,
    input  logic          wen2,
    input  reg_addr_t     wa2,
    input  logic          wb2_long,
    output logic          issue_a,
    output logic          issue_b,
    output logic [PW-1:0] pending,
    output logic          full
);

    logic            clr1;
    logic            clr2;
    logic            set_a;
    logic            set_b;
    logic            a_dst_chk;
    logic            b_dst_chk;
    logic            ok_a;
    logic            ok_b;
    logic            raw_ab;
    logic            waw_ab;
    logic            room_a;
    logic            room_b;
    int              pend_eff;
    reg_addr_t [5:0] rd_addr;
    logic      [5:0] rdy;

    assign clr1 = wen1 & wb1_long & (wa1 != '0);
    assign clr2 = wen2 & wb2_long & (wa2 != '0);

    assign rd_addr = {b_dst, a_dst, b_rt, b_rs, a_rt, a_rs};

    sb_busy_table u_busy (
        .clk       (clk),
        .rst       (rst),
        .set1      (set_a),
        .set_addr1 (a_dst),
        .set2      (set_b),
        .set_addr2 (b_dst),
        .clr1      (clr1),
        .clr_addr1 (wa1),
        .clr2      (clr2),
        .clr_addr2 (wa2),
        .rd_addr   (rd_addr),
        .rdy       (rdy)
    );

    // Writebacks completing this cycle free their slots immediately
    assign pend_eff = int'(pending) - int'(clr1) - int'(clr2);

    assign a_dst_chk = a_wen & (a_dst != '0);
    assign b_dst_chk = b_wen & (b_dst != '0);

    assign room_a = ~a_long | (pend_eff < MAX_PENDING);
    assign room_b = ~b_long
                  | ((pend_eff + int'(a_long & issue_a)) < MAX_PENDING);

    assign ok_a = (~a_rs_use | rdy[0])
                & (~a_rt_use | rdy[1])
                & (~a_dst_chk | rdy[4])
                & room_a;

    assign issue_a = a_valid & ok_a & ~stall_i & ~flush_i & ~rst;

    assign raw_ab = a_dst_chk
                  & ((b_rs_use & (b_rs == a_dst))
                   | (b_rt_use & (b_rt == a_dst)));
    assign waw_ab = a_dst_chk & b_wen & (b_dst == a_dst);

    assign ok_b = (~b_rs_use | rdy[2])
                & (~b_rt_use | rdy[3])
                & (~b_dst_chk | rdy[5])
                & ~raw_ab
                & ~waw_ab
                & ~(a_long & b_long)
                & room_b;

    assign issue_b = issue_a & b_valid & ok_b;

    assign set_a = issue_a & a_long & a_dst_chk;
    assign set_b = issue_b & b_long & b_dst_chk;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending + PW'(set_a) + PW'(set_b)
                     - PW'(clr1) - PW'(clr2);
        end
    end

    assign full = (pending == PW'(MAX_PENDING));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios then random traffic,
// checked against a per-register busy model (pending = busy count).
module tb_issue_scoreboard;

    localparam int MAXP = 3;
    localparam int PW   = $clog2(MAXP + 1);

    logic          clk;
    logic          rst;
    logic          stall_i;
    logic          flush_i;
    logic          a_valid;
    logic          b_valid;
    logic [4:0]    a_rs;
    logic [4:0]    a_rt;
    logic [4:0]    b_rs;
    logic [4:0]    b_rt;
    logic          a_rs_use;
    logic          a_rt_use;
    logic          b_rs_use;
    logic          b_rt_use;
    logic          a_wen;
    logic          b_wen;
    logic [4:0]    a_dst;
    logic [4:0]    b_dst;
    logic          a_long;
    logic          b_long;
    logic          wen1;
    logic [4:0]    wa1;
    logic          wb1_long;
    logic          wen2;
    logic [4:0]    wa2;
    logic          wb2_long;
    logic          issue_a;
    logic          issue_b;
    logic [PW-1:0] pending;
    logic          full;

    int checks = 0;
    int errors = 0;
    bit m_busy [32];

    issue_scoreboard #(.MAX_PENDING(MAXP)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .a_rs     (a_rs),
        .a_rt     (a_rt),
        .b_rs     (b_rs),
        .b_rt     (b_rt),
        .a_rs_use (a_rs_use),
        .a_rt_use (a_rt_use),
        .b_rs_use (b_rs_use),
        .b_rt_use (b_rt_use),
        .a_wen    (a_wen),
        .b_wen    (b_wen),
        .a_dst    (a_dst),
        .b_dst    (b_dst),
        .a_long   (a_long),
        .b_long   (b_long),
        .wen1     (wen1),
        .wa1      (wa1),
        .wb1_long (wb1_long),
        .wen2     (wen2),
        .wa2      (wa2),
        .wb2_long (wb2_long),
        .issue_a  (issue_a),
        .issue_b  (issue_b),
        .pending  (pending),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 0; stall_i = 0; flush_i = 0;
        a_valid = 0; b_valid = 0;
        a_rs = 0; a_rt = 0; b_rs = 0; b_rt = 0;
        a_rs_use = 0; a_rt_use = 0; b_rs_use = 0; b_rt_use = 0;
        a_wen = 0; b_wen = 0; a_dst = 0; b_dst = 0;
        a_long = 0; b_long = 0;
        wen1 = 0; wa1 = 0; wb1_long = 0;
        wen2 = 0; wa2 = 0; wb2_long = 0;
    endtask

    function automatic int busy_count();
        int n = 0;
        for (int r = 1; r < 32; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    // Evaluate current inputs against the model, then advance the model.
    task automatic cyc();
        bit rdy [32];
        bit c1, c2, da, db, ea, eb;
        int cnt, pe;
        #1;
        c1 = wen1 && wb1_long && wa1 != 0;
        c2 = wen2 && wb2_long && wa2 != 0;
        for (int r = 0; r < 32; r++)
            rdy[r] = !m_busy[r] || (c1 && wa1 == r) || (c2 && wa2 == r);
        cnt = busy_count();
        pe  = cnt - int'(c1) - int'(c2);
        da  = a_wen && a_dst != 0;
        db  = b_wen && b_dst != 0;
        ea  = a_valid && !stall_i && !flush_i && !rst
            && (!a_rs_use || rdy[a_rs]) && (!a_rt_use || rdy[a_rt])
            && (!da || rdy[a_dst]) && (!a_long || pe < MAXP);
        eb  = ea && b_valid
            && (!b_rs_use || rdy[b_rs]) && (!b_rt_use || rdy[b_rt])
            && (!db || rdy[b_dst])
            && !(da && b_rs_use && b_rs == a_dst)
            && !(da && b_rt_use && b_rt == a_dst)
            && !(da && db && a_dst == b_dst)
            && !(a_long && b_long)
            && (!b_long || pe + int'(a_long && ea) < MAXP);
        check("issue_a", int'(issue_a), int'(ea));
        check("issue_b", int'(issue_b), int'(eb));
        check("pending", int'(pending), cnt);
        check("full", int'(full), int'(cnt == MAXP));
        if (rst) begin
            foreach (m_busy[r]) m_busy[r] = 0;
        end else begin
            if (c1) m_busy[wa1] = 0;
            if (c2) m_busy[wa2] = 0;
            if (ea && da && a_long) m_busy[a_dst] = 1;
            if (eb && db && b_long) m_busy[b_dst] = 1;
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        idle();
    endtask

    task automatic rand_in();
        int bl[$];
        int k;
        idle();
        rst      = ($urandom_range(0, 199) == 0);
        stall_i  = ($urandom_range(0, 9) == 0);
        flush_i  = ($urandom_range(0, 11) == 0);
        a_valid  = ($urandom_range(0, 9) != 0);
        b_valid  = ($urandom_range(0, 3) != 0);
        a_rs     = 5'($urandom_range(0, 7));
        a_rt     = 5'($urandom_range(0, 7));
        b_rs     = 5'($urandom_range(0, 7));
        b_rt     = 5'($urandom_range(0, 7));
        a_dst    = 5'($urandom_range(0, 7));
        b_dst    = 5'($urandom_range(0, 7));
        a_rs_use = 1'($urandom_range(0, 1));
        a_rt_use = 1'($urandom_range(0, 1));
        b_rs_use = 1'($urandom_range(0, 1));
        b_rt_use = 1'($urandom_range(0, 1));
        a_wen    = 1'($urandom_range(0, 1));
        b_wen    = 1'($urandom_range(0, 1));
        a_long   = ($urandom_range(0, 2) == 0);
        b_long   = ($urandom_range(0, 2) == 0);
        for (int r = 1; r < 32; r++) if (m_busy[r]) bl.push_back(r);
        if (bl.size() > 0 && $urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, bl.size() - 1);
            wen1 = 1; wb1_long = 1; wa1 = 5'(bl[k]);
            bl.delete(k);
        end else begin
            wen1 = 1'($urandom_range(0, 1));
            wa1  = 5'($urandom_range(0, 31));
        end
        if (bl.size() > 0 && $urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, bl.size() - 1);
            wen2 = 1; wb2_long = 1; wa2 = 5'(bl[k]);
        end else begin
            wen2 = 1'($urandom_range(0, 1));
            wa2  = 5'($urandom_range(0, 31));
        end
    endtask

    initial begin
        foreach (m_busy[r]) m_busy[r] = 0;
        idle();
        rst = 1; a_valid = 1;
        @(negedge clk);
        cyc();
        check("rst_ia", int'(issue_a), 0);
        check("rst_pend", int'(pending), 0);
        nxt();

        // long load to r5, dependent read waits for its writeback
        a_valid = 1; a_wen = 1; a_dst = 5; a_long = 1;
        cyc(); check("ld_ia", int'(issue_a), 1); nxt();
        repeat (2) begin
            a_valid = 1; a_rs = 5; a_rs_use = 1;
            cyc(); check("raw5_ia", int'(issue_a), 0); nxt();
        end
        a_valid = 1; a_rs = 5; a_rs_use = 1;
        wen1 = 1; wa1 = 5; wb1_long = 1;
        cyc(); check("wb5_ia", int'(issue_a), 1); nxt();

        // intra-pair RAW on r3
        a_valid = 1; a_wen = 1; a_dst = 3;
        b_valid = 1; b_rs = 3; b_rs_use = 1; b_wen = 1; b_dst = 4;
        cyc();
        check("pair_ia", int'(issue_a), 1);
        check("pair_ib", int'(issue_b), 0);
        check("wb5_pend", int'(pending), 0);
        nxt();
        a_valid = 1; a_rs = 3; a_rs_use = 1; a_wen = 1; a_dst = 4;
        cyc(); check("slv_ia", int'(issue_a), 1); nxt();

        // fill to MAXP, then release with a same-cycle port-2 writeback
        for (int i = 0; i < MAXP; i++) begin
            a_valid = 1; a_wen = 1; a_long = 1; a_dst = 5'(10 + i);
            cyc(); check("fill_ia", int'(issue_a), 1); nxt();
        end
        a_valid = 1; a_wen = 1; a_long = 1; a_dst = 13;
        cyc();
        check("full_f", int'(full), 1);
        check("full_ia", int'(issue_a), 0);
        nxt();
        a_valid = 1; a_wen = 1; a_long = 1; a_dst = 13;
        wen2 = 1; wa2 = 10; wb2_long = 1;
        cyc(); check("rel_ia", int'(issue_a), 1); nxt();

        // reset with MAXP outstanding
        rst = 1; a_valid = 1;
        cyc();
        check("pre_rst_pend", int'(pending), MAXP);
        check("rst3_ia", int'(issue_a), 0);
        nxt();
        a_valid = 1; a_rs = 11; a_rs_use = 1; a_rt = 12; a_rt_use = 1;
        a_wen = 1; a_dst = 13;
        cyc();
        check("post_rst_pend", int'(pending), 0);
        check("post_rst_ia", int'(issue_a), 1);
        nxt();

        // two longs in one pair; long op to r0
        a_valid = 1; a_wen = 1; a_long = 1; a_dst = 14;
        b_valid = 1; b_wen = 1; b_long = 1; b_dst = 15;
        cyc();
        check("ll_ia", int'(issue_a), 1);
        check("ll_ib", int'(issue_b), 0);
        nxt();
        a_valid = 1; a_wen = 1; a_long = 1; a_dst = 0;
        cyc(); check("r0_ia", int'(issue_a), 1); nxt();
        cyc(); check("r0_pend", int'(pending), 1); nxt();

        // flush keeps r7 busy
        a_valid = 1; a_wen = 1; a_long = 1; a_dst = 7;
        cyc(); nxt();
        flush_i = 1;
        a_valid = 1; a_wen = 1; a_dst = 20;
        b_valid = 1; b_wen = 1; b_dst = 21;
        cyc();
        check("fl_ia", int'(issue_a), 0);
        check("fl_ib", int'(issue_b), 0);
        nxt();
        a_valid = 1; a_rs = 7; a_rs_use = 1;
        cyc(); check("r7_busy", int'(issue_a), 0); nxt();
        a_valid = 1; a_rs = 7; a_rs_use = 1;
        wen1 = 1; wa1 = 7; wb1_long = 1;
        cyc(); check("r7_wb", int'(issue_a), 1); nxt();
        cyc(); check("r7_pend", int'(pending), 1); nxt();

        repeat (3000) begin
            rand_in();
            cyc();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
